// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, DATA_MEMORY
// size codes, FSM states and small width helpers.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } lsu_state_e;

  // DATA_MEMORY size code for a funct3[1:0] width field
  function automatic logic [1:0] size_code(input logic [1:0] w);
    case (w)
      2'b00:   size_code = SIZE_B;
      2'b01:   size_code = SIZE_H;
      default: size_code = SIZE_W;
    endcase
  endfunction

  // Access width in bytes for a funct3[1:0] width field
  function automatic logic [2:0] access_bytes(input logic [1:0] w);
    case (w)
      2'b00:   access_bytes = 3'd1;
      2'b01:   access_bytes = 3'd2;
      default: access_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Combinational sign/zero extension of raw DATA_MEMORY read data by funct3.
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] ext
);

  // Select extension mode from the load funct3
  always_comb begin
    ext = raw;
    case (funct3)
      F3_LB:   ext = {{24{raw[7]}}, raw[7:0]};
      F3_LH:   ext = {{16{raw[15]}}, raw[15:0]};
      F3_LBU:  ext = {24'h0, raw[7:0]};
      F3_LHU:  ext = {16'h0, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one RV32 load/store request, drives a single
// DATA_MEMORY access and returns an extended result or an error flag.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (reject misaligned half/word).
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 8,
  parameter int MEM_WAIT  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  output logic        mem_we,
  output logic [1:0]  mem_size,
  input  logic [31:0] mem_data_out
);

  localparam logic [3:0]  WAIT_CYC = 4'(MEM_WAIT);
  localparam logic [32:0] MEM_END  = 33'(MEM_BYTES);

  lsu_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_data_in_q, mem_data_in_d;
  logic [1:0]  mem_size_q, mem_size_d;

  logic [32:0] end_addr;
  logic        req_illegal;
  logic [31:0] ext_data;

  lsu_load_ext u_load_ext (
    .funct3 (funct3_q),
    .raw    (mem_data_out),
    .ext    (ext_data)
  );

  // Legality of the presented request: funct3, store width, range, alignment
  always_comb begin
    end_addr    = {1'b0, req_addr} + {30'h0, access_bytes(req_funct3[1:0])};
    req_illegal = (req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110) ||
                  (req_we && req_funct3[2]) || (end_addr > MEM_END);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((req_funct3[1:0] == 2'b01) && req_addr[0])
      req_illegal = 1'b1;
    if ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00))
      req_illegal = 1'b1;
`endif
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    funct3_d      = funct3_q;
    cnt_d         = cnt_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_data_in_d = mem_data_in_q;
    mem_size_d    = mem_size_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          rdata_d  = '0;
          err_d    = req_illegal;
          cnt_d    = '0;
          if (req_illegal) begin
            state_d = RESP;
          end else begin
            // memory-side registers only move for accesses actually issued
            state_d       = ISSUE;
            mem_addr_d    = req_addr;
            mem_data_in_d = req_wdata;
            mem_size_d    = size_code(req_funct3[1:0]);
            mem_we_d      = req_we;
          end
        end
      end
      ISSUE: begin
        if (cnt_q == WAIT_CYC) begin
          state_d = RESP;
          if (!we_q)
            rdata_d = ext_data;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        if (resp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      we_q          <= 1'b0;
      funct3_q      <= '0;
      cnt_q         <= '0;
      rdata_q       <= '0;
      err_q         <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
      mem_size_q    <= '0;
    end else begin
      state_q       <= state_d;
      we_q          <= we_d;
      funct3_q      <= funct3_d;
      cnt_q         <= cnt_d;
      rdata_q       <= rdata_d;
      err_q         <= err_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_in_q <= mem_data_in_d;
      mem_size_q    <= mem_size_d;
    end
  end

  assign req_ready   = (state_q == IDLE) && !rst;
  assign resp_valid  = (state_q == RESP);
  assign resp_rdata  = rdata_q;
  assign resp_err    = err_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data_in = mem_data_in_q;
  assign mem_size    = mem_size_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a big-endian byte memory
// attached and a byte-array reference model of load/store semantics.
module tb_load_store_unit;

  localparam int MB = 8;
  localparam int MW = 0;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_in;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_data_out;

  int total = 0;
  int bad   = 0;

  logic [7:0] phys    [0:MB-1];
  logic [7:0] ref_mem [0:MB-1];

  load_store_unit #(.MEM_BYTES(MB), .MEM_WAIT(MW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_we       (mem_we),
    .mem_size     (mem_size),
    .mem_data_out (mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int size_bytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  // Big-endian DATA_MEMORY: combinational read, write on rising edge
  always @* begin
    int n;
    n = size_bytes(mem_size);
    mem_data_out = '0;
    for (int i = 0; i < n; i++) begin
      mem_data_out = mem_data_out << 8;
      if (mem_addr + 32'(i) < 32'(MB))
        mem_data_out[7:0] = phys[mem_addr + 32'(i)];
    end
  end

  always @(posedge clk) begin
    if (mem_we) begin
      int n;
      n = size_bytes(mem_size);
      for (int i = 0; i < n; i++)
        if (mem_addr + 32'(i) < 32'(MB))
          phys[mem_addr + 32'(i)] = 8'(mem_data_in >> (8 * (n - 1 - i)));
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference semantics: legality, load value, store effect on ref_mem
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic err, output logic [31:0] data);
    int n;
    longint v;
    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    err = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3[2]) ||
          (longint'(a) + longint'(n) > longint'(MB));
`ifdef LSU_MISALIGN_TRAP_EN
    if (n == 2 && (a % 2) != 0) err = 1'b1;
    if (n == 4 && (a % 4) != 0) err = 1'b1;
`endif
    data = '0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < n; i++)
          ref_mem[int'(a) + i] = 8'(wd >> (8 * (n - 1 - i)));
      end else begin
        v = 0;
        for (int i = 0; i < n; i++)
          v = v * 256 + longint'(ref_mem[int'(a) + i]);
        if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1)))
          v = v - (longint'(1) << (8 * n));
        data = 32'(v);
      end
    end
  endtask

  // One request/response transaction, with `hold` cycles of response backpressure
  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input int hold, input string tag);
    logic        e_err;
    logic [31:0] e_data;
    int          lat;
    int          wec;
    logic [1:0]  sz;
    int          n;
    model(we, f3, a, wd, e_err, e_data);
    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    resp_ready = 1'b0;
    check_val({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_addr   = $urandom;
    req_wdata  = $urandom;
    req_funct3 = 3'($urandom_range(0, 7));
    wec = 0;
    sz  = 2'd2;
    if (mem_we) begin wec++; sz = mem_size; end
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (mem_we) begin wec++; sz = mem_size; end
    end
    check_val({tag, ".latency"}, 32'(lat), e_err ? 32'd0 : 32'(1 + MW));
    check_val({tag, ".err"}, 32'(resp_err), 32'(e_err));
    check_val({tag, ".rdata"}, resp_rdata, e_data);
    check_val({tag, ".we_cycles"}, 32'(wec), (we && !e_err) ? 32'd1 : 32'd0);
    if (we && !e_err)
      check_val({tag, ".size"}, 32'(sz), (n == 1) ? 32'd0 : (n == 2) ? 32'd1 : 32'd3);
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      check_val({tag, ".hold_valid"}, 32'(resp_valid), 32'd1);
      check_val({tag, ".hold_rdata"}, resp_rdata, e_data);
      check_val({tag, ".hold_err"}, 32'(resp_err), 32'(e_err));
      check_val({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
      check_val({tag, ".hold_we"}, 32'(mem_we), 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check_val({tag, ".after_valid"}, 32'(resp_valid), 32'd0);
    check_val({tag, ".after_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] b03;
    int seen;
    logic [7:0] init_bytes [0:7];
    init_bytes = '{8'h80, 8'h01, 8'h7F, 8'hFF, 8'h12, 8'h34, 8'h56, 8'h78};
    for (int i = 0; i < MB; i++) begin
      phys[i]    = init_bytes[i];
      ref_mem[i] = init_bytes[i];
    end
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = '0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;
    #12;
    check_val("rst.req_ready", 32'(req_ready), 32'd0);
    check_val("rst.resp_valid", 32'(resp_valid), 32'd0);
    check_val("rst.resp_rdata", resp_rdata, 32'd0);
    check_val("rst.resp_err", 32'(resp_err), 32'd0);
    check_val("rst.mem_we", 32'(mem_we), 32'd0);
    check_val("rst.mem_addr", mem_addr, 32'd0);
    check_val("rst.mem_data_in", mem_data_in, 32'd0);
    check_val("rst.mem_size", 32'(mem_size), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    xact(1'b0, 3'b000, 32'd0, 32'd0, 0, "lb0");
    check_val("lb0.value", resp_rdata, 32'hFFFFFF80);
    xact(1'b0, 3'b100, 32'd0, 32'd0, 0, "lbu0");
    xact(1'b0, 3'b001, 32'd2, 32'd0, 0, "lh2");
    xact(1'b0, 3'b010, 32'd4, 32'd0, 0, "lw4");
    xact(1'b1, 3'b001, 32'd6, 32'hAAAABEEF, 3, "sh6");
    xact(1'b0, 3'b010, 32'd4, 32'd0, 0, "lw4b");
    xact(1'b0, 3'b010, 32'd6, 32'd0, 0, "lw6_range");
    xact(1'b0, 3'b011, 32'd0, 32'd0, 0, "f3_011");
    xact(1'b1, 3'b100, 32'd0, 32'd0, 0, "sbu_illegal");
    xact(1'b0, 3'b001, 32'd1, 32'd0, 1, "lh1_misalign");

    // Reset asserted in the accept cycle: request must be dropped
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'd0;
    req_wdata  = 32'hDEADBEEF;
    rst        = 1'b1;
    #1;
    check_val("rstmid.req_ready_in_rst", 32'(req_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      if (resp_valid || mem_we) seen++;
    end
    check_val("rstmid.no_activity", 32'(seen), 32'd0);
    check_val("rstmid.req_ready", 32'(req_ready), 32'd1);
    b03 = {phys[0], phys[1], phys[2], phys[3]};
    check_val("rstmid.bytes0_3", b03, 32'h80017FFF);

    for (int t = 0; t < 40; t++) begin
      logic we;
      logic [2:0] f3;
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      xact(we, f3, 32'($urandom_range(0, 9)), $urandom, $urandom_range(0, 2), "rnd");
    end
    for (int i = 0; i < MB; i++)
      check_val("final.mem", 32'(phys[i]), 32'(ref_mem[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequential initiator that drives the byte-addressed, big-endian `DATA_MEMORY` port on behalf of the core's execute stage. It accepts one RV32 load/store request through a valid/ready handshake and issues a single memory access with the correct `size` code. For loads it captures `data_out` and sign- or zero-extends it. It returns a response with data or an error flag, and it is the only block that drives `DATA_MEMORY`.

## Interface
- `MEM_BYTES`, 8: data memory depth in bytes, used for range checking.
- `MEM_WAIT`, 0: extra cycles the address is held before read data is captured (0..15).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when high together with `req_valid`.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32 funct3: LB 000, LH 001, LW 010, LBU 100, LHU 101, SB 000, SH 001, SW 010.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data; the low bytes are used.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  response consumed when high together with `resp_valid`.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_err`  out  1  access rejected; memory was not touched.
- `mem_addr`  out  32  to `DATA_MEMORY.addr`.
- `mem_data_in`  out  32  to `DATA_MEMORY.data_in`.
- `mem_we`  out  1  to `DATA_MEMORY.we`.
- `mem_size`  out  2  to `DATA_MEMORY.size`: byte 0, half 1, word 3. The value 2 is never issued.
- `mem_data_out`  in  32  from `DATA_MEMORY.data_out`.

## Operation
- **FSM states and transitions:**
  - IDLE → ISSUE on a handshake when the request is legal.
  - IDLE → RESP on a handshake when the request is illegal.
  - ISSUE → RESP after 1+`MEM_WAIT` cycles.
  - RESP → IDLE when `resp_ready` is high.
- **Ready:** `req_ready` = (state==IDLE) && !rst.
- **Request latching:** on acceptance, latch `req_we`, `req_funct3`, `req_addr`, `req_wdata`. `req_*` inputs are ignored outside IDLE.
- **Access width:** nbytes = 1/2/4 from funct3[1:0].
- **Illegal requests:**
  - funct3 ∈ {011, 110, 111}.
  - A store with funct3[2]=1.
  - `req_addr` + nbytes > `MEM_BYTES`, computed in 33-bit arithmetic so no wrap-around.
- **In ISSUE:**
  - `mem_addr` = latched address; `mem_size` comes from the width; `mem_data_in` = latched wdata.
  - For stores, `mem_we` is high in the first ISSUE cycle only.
  - For loads, `mem_data_out` is captured into the response register on the last ISSUE cycle. A 4-bit counter tracks `MEM_WAIT`.
- **Outside ISSUE:** `mem_we` = 0. `mem_addr`, `mem_size` and `mem_data_in` hold their last values.
- **Load extension:**
  - LB sign-extends bit 7 of `mem_data_out[7:0]`.
  - LH sign-extends bit 15 of `mem_data_out[15:0]`.
  - LBU and LHU zero-extend.
  - LW passes the value through.
- **Store response:** `resp_rdata` = 0, `resp_err` = 0.

## Timing
- **Reset values:** `req_ready` 0 while `rst` is high; `resp_valid` 0, `resp_rdata` 0, `resp_err` 0, `mem_we` 0, `mem_addr` 0, `mem_data_in` 0, `mem_size` 0. All take effect immediately (asynchronous).
- **Latency, legal access:** acceptance at edge N → ISSUE for cycles N..N+`MEM_WAIT` → `resp_valid` high from edge N+1+`MEM_WAIT`. With the default `MEM_WAIT`=0 this is 2 cycles from request to response.
- **Latency, illegal access:** `resp_valid` rises one cycle after acceptance with `resp_err`=1. No memory cycle is issued.
- **Response hold:** `resp_valid`, `resp_rdata` and `resp_err` stay stable until the handshake. A new request is accepted no earlier than the cycle after the response handshake.
- **Reset mid-operation:** `rst` in any state returns the FSM to IDLE and forces `mem_we` low at once. The pending response is discarded and never presented.
- **Simultaneous `rst` and handshake:** reset wins; the request is not accepted.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Halfword at an odd address is illegal (`resp_err`=1, no memory access).
  - Word with addr[1:0]≠0 is illegal in the same way.
- `LSU_MISALIGN_TRAP_EN` undefined: misaligned accesses are issued as-is, since the memory handles any byte address. Only the range and funct3 checks apply.

## Structure
- **`lsu_pkg`:**
  - funct3 constants (LB..SW).
  - Memory size codes: SIZE_B=0, SIZE_H=1, SIZE_W=3.
  - FSM state enum: IDLE, ISSUE, RESP.
- **`lsu_load_ext`:** purely combinational sub-module taking funct3 and the raw 32-bit memory data and producing the extended result. It is instantiated once, at the capture point.

## Test plan
The memory is preloaded with bytes 0..7 = 80 01 7F FF 12 34 56 78.
- **Load extension:**
  - LB at 0 → 0xFFFFFF80.
  - LBU at 0 → 0x00000080.
  - LH at 2 → 0x00007FFF.
  - LW at 4 → 0x12345678.
  - Each response arrives 2 cycles after acceptance with `resp_err`=0.
- **Store then load:** SH at 6 with wdata 0xAAAABEEF → `mem_we` high for exactly 1 cycle with `mem_size`=1. A following LW at 4 → 0x1234BEEF.
- **Out-of-range and illegal funct3:**
  - LW at 6 → `resp_err`=1 one cycle after acceptance; `mem_we` never rises.
  - funct3=011 → `resp_err`=1.
- **Misalignment:**
  - LH at 1 with `LSU_MISALIGN_TRAP_EN` defined → `resp_err`=1.
  - LH at 1 with the macro undefined → 0x0000017F.
- **Backpressure:** `resp_ready` held low for 3 cycles → `resp_valid` and the data stay stable, and `req_ready` stays 0. Asserting `resp_ready` returns `req_ready` to 1 on the next cycle.
- **Reset mid-operation:** SW at 0 with wdata 0xDEADBEEF, `rst` pulsed in the accept cycle → no write occurs (bytes 0..3 still 80 01 7F FF). `resp_valid` never rises, and `req_ready` is 1 after reset releases.
